// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, register select, writeback arbiter state and result entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REGSEL_W = 5;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGSEL_W-1:0] regsel_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        FORCE     = 2'd1,
        HALT_WAIT = 2'd2,
        HALTED    = 2'd3
    } wb_arb_state_t;

    typedef struct packed {
        regsel_t wsel;
        word_t   wdat;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding long-latency-unit results waiting for the register-file write port.
// Latency: an entry pushed on one edge is visible at head from the next cycle.
// Backpressure: push is ignored when full, pop is ignored when empty; caller watches full/empty.
module wb_result_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          push,
    input  wb_entry_t     push_dat,
    input  logic          pop,
    output wb_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage array; contents are don't-care until the count says otherwise, so no reset.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; reset empties the FIFO and drops anything pending.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline writeback and queued LLU results; handles halt drain.
// Latency: pipe writes pass through the same cycle; LLU results write no earlier than the cycle after acceptance.
// Backpressure: llu_ready drops when the FIFO is full or halted; pipe_stall holds the pipeline for one forced-drain cycle.
// Optional build macro WB_ARB_STATS_EN adds a stall_count output counting forced-drain cycles.
module wb_port_arbiter
    import cpu_types_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic    CLK,
    input  logic    nRST,
    input  logic    pipe_wen,
    input  regsel_t pipe_wsel,
    input  word_t   pipe_wdat,
    input  logic    llu_valid,
    input  regsel_t llu_wsel,
    input  word_t   llu_wdat,
    output logic    llu_ready,
    input  logic    temp_halt,
    output logic    rf_wen,
    output regsel_t rf_wsel,
    output word_t   rf_wdat,
    output logic    pipe_stall,
    output logic    halt
`ifdef WB_ARB_STATS_EN
    ,
    output logic [31:0] stall_count
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_arb_state_t r_state;
    logic [SW-1:0] r_starve;
    logic          r_halt_latch;
    logic          r_halt;
    logic          r_pipe_stall;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    wb_entry_t     w_head;
    wb_entry_t     w_push_dat;
    logic [SW-1:0] w_starve_nxt;
    logic          w_starve_hit;
    logic          w_drained;

    // Results to r0 are accepted from the LLU but never stored.
    assign llu_ready        = !w_full && (r_state != HALTED);
    assign w_push           = llu_valid && llu_ready && (llu_wsel != '0);
    assign w_push_dat.wsel  = llu_wsel;
    assign w_push_dat.wdat  = llu_wdat;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .push     (w_push),
        .push_dat (w_push_dat),
        .pop      (w_pop),
        .head     (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (w_count)
    );

    // Write-port mux: pipe has priority unless forced drain; a pipe write to r0 yields the port.
    always_comb begin
        rf_wen  = 1'b0;
        rf_wsel = '0;
        rf_wdat = '0;
        w_pop   = 1'b0;
        case (r_state)
            RUN, HALT_WAIT: begin
                if (pipe_wen && (pipe_wsel != '0)) begin
                    rf_wen  = 1'b1;
                    rf_wsel = pipe_wsel;
                    rf_wdat = pipe_wdat;
                end else if (!w_empty) begin
                    rf_wen  = 1'b1;
                    rf_wsel = w_head.wsel;
                    rf_wdat = w_head.wdat;
                    w_pop   = 1'b1;
                end
            end
            FORCE: begin
                if (!w_empty) begin
                    rf_wen  = 1'b1;
                    rf_wsel = w_head.wsel;
                    rf_wdat = w_head.wdat;
                    w_pop   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Starvation count of the FIFO head: clears on pop or empty, saturates at the limit.
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (r_starve != SW'(STARVE_LIMIT)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    assign w_starve_hit = (w_starve_nxt == SW'(STARVE_LIMIT));
    // FIFO will be empty after this edge and nothing new arrives.
    assign w_drained    = (w_count == CW'(w_pop)) && !w_push;

    // Arbiter FSM with registered stall and halt outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= RUN;
            r_starve     <= '0;
            r_halt_latch <= 1'b0;
            r_halt       <= 1'b0;
            r_pipe_stall <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            case (r_state)
                RUN: begin
                    if (w_starve_hit) begin
                        r_state      <= FORCE;
                        r_pipe_stall <= 1'b1;
                        r_halt_latch <= temp_halt;
                    end else if (temp_halt) begin
                        r_state <= HALT_WAIT;
                    end
                end
                FORCE: begin
                    r_pipe_stall <= 1'b0;
                    r_halt_latch <= 1'b0;
                    r_state      <= (r_halt_latch || temp_halt) ? HALT_WAIT : RUN;
                end
                HALT_WAIT: begin
                    if (w_drained) begin
                        r_state <= HALTED;
                        r_halt  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= HALTED;
                    r_halt  <= 1'b1;
                end
            endcase
        end
    end

    assign pipe_stall = r_pipe_stall;
    assign halt       = r_halt;

`ifdef WB_ARB_STATS_EN
    logic [31:0] r_stall_count;

    // Forced-drain cycle counter, wraps naturally.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_count <= '0;
        end else if (r_state == FORCE) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with a queue-based reference model checked every falling edge.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        pipe_wen = 1'b0;
    logic [4:0]  pipe_wsel = '0;
    logic [31:0] pipe_wdat = '0;
    logic        llu_valid = 1'b0;
    logic [4:0]  llu_wsel = '0;
    logic [31:0] llu_wdat = '0;
    logic        temp_halt = 1'b0;
    logic        llu_ready;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        pipe_stall;
    logic        halt;
`ifdef WB_ARB_STATS_EN
    logic [31:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_port_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .pipe_wen   (pipe_wen),
        .pipe_wsel  (pipe_wsel),
        .pipe_wdat  (pipe_wdat),
        .llu_valid  (llu_valid),
        .llu_wsel   (llu_wsel),
        .llu_wdat   (llu_wdat),
        .llu_ready  (llu_ready),
        .temp_halt  (temp_halt),
        .rf_wen     (rf_wen),
        .rf_wsel    (rf_wsel),
        .rf_wdat    (rf_wdat),
        .pipe_stall (pipe_stall),
        .halt       (halt)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    // Reference model: pending LLU results as a queue plus a few mode flags.
    logic [36:0] m_q[$];
    int          m_wait = 0;
    logic        m_force = 1'b0;
    logic        m_hw = 1'b0;
    logic        m_halted = 1'b0;
    logic        m_hreq = 1'b0;

    always @(negedge CLK) begin : model_cmp
        logic        e_ready;
        logic        e_wen;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
        logic        pop;
        logic        was_empty;
        if (!nRST) begin
            m_q.delete();
            m_wait   = 0;
            m_force  = 1'b0;
            m_hw     = 1'b0;
            m_halted = 1'b0;
            m_hreq   = 1'b0;
            chk("rst_rf_wen", 32'(rf_wen), 32'd0);
            chk("rst_ready", 32'(llu_ready), 32'd1);
            chk("rst_stall", 32'(pipe_stall), 32'd0);
            chk("rst_halt", 32'(halt), 32'd0);
        end else begin
            was_empty = (m_q.size() == 0);
            e_ready   = !m_halted && (m_q.size() < DEPTH);
            e_wen = 1'b0; e_sel = '0; e_dat = '0; pop = 1'b0;
            if (m_halted) begin
                e_wen = 1'b0;
            end else if (m_force) begin
                if (!was_empty) begin
                    e_wen = 1'b1; {e_sel, e_dat} = m_q[0]; pop = 1'b1;
                end
            end else if (pipe_wen && pipe_wsel != 5'd0) begin
                e_wen = 1'b1; e_sel = pipe_wsel; e_dat = pipe_wdat;
            end else if (!was_empty) begin
                e_wen = 1'b1; {e_sel, e_dat} = m_q[0]; pop = 1'b1;
            end
            chk("m_ready", 32'(llu_ready), 32'(e_ready));
            chk("m_stall", 32'(pipe_stall), 32'(m_force));
            chk("m_halt", 32'(halt), 32'(m_halted));
            chk("m_rf_wen", 32'(rf_wen), 32'(e_wen));
            if (e_wen) begin
                chk("m_rf_wsel", 32'(rf_wsel), 32'(e_sel));
                chk("m_rf_wdat", rf_wdat, e_dat);
            end
            if (pop) void'(m_q.pop_front());
            if (llu_valid && e_ready && llu_wsel != 5'd0) m_q.push_back({llu_wsel, llu_wdat});
            m_wait = (was_empty || pop) ? 0 : ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1);
            if (m_force) begin
                m_force = 1'b0;
                if (m_hreq || temp_halt) m_hw = 1'b1;
                m_hreq = 1'b0;
            end else if (m_hw) begin
                if (m_q.size() == 0) begin
                    m_hw = 1'b0; m_halted = 1'b1;
                end
            end else if (!m_halted) begin
                if (m_wait == LIMIT) begin
                    m_force = 1'b1; m_hreq = temp_halt;
                end else if (temp_halt) begin
                    m_hw = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic pw, input logic [4:0] ps, input logic [31:0] pd,
                          input logic lv, input logic [4:0] ls, input logic [31:0] ld,
                          input logic th);
        pipe_wen = pw; pipe_wsel = ps; pipe_wdat = pd;
        llu_valid = lv; llu_wsel = ls; llu_wdat = ld;
        temp_halt = th;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick; tick;
        #1;
        chk("reset_rf_wen", 32'(rf_wen), 32'd0);
        chk("reset_llu_ready", 32'(llu_ready), 32'd1);
        nRST = 1'b1;
        tick;

        // Single LLU result with idle pipe.
        set_in(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        #1 chk("t1_push_rf_wen", 32'(rf_wen), 32'd0);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_rf_wen", 32'(rf_wen), 32'd1);
        chk("t1_rf_wsel", 32'(rf_wsel), 32'd5);
        chk("t1_rf_wdat", rf_wdat, 32'hDEADBEEF);
        chk("t1_ready", 32'(llu_ready), 32'd1);
        tick;

        // Busy pipe starves one LLU result until a forced drain.
        set_in(1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0);
        tick;
        set_in(1, 5'd3, 32'h33, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            #1 chk("t2_pipe_wsel", 32'(rf_wsel), 32'd3);
            chk("t2_no_stall", 32'(pipe_stall), 32'd0);
            tick;
        end
        #1;
        chk("t2_stall", 32'(pipe_stall), 32'd1);
        chk("t2_force_wsel", 32'(rf_wsel), 32'd7);
        chk("t2_force_wdat", rf_wdat, 32'h77);
        tick;
        #1;
        chk("t2_resume_stall", 32'(pipe_stall), 32'd0);
        chk("t2_resume_wsel", 32'(rf_wsel), 32'd3);
        tick;

        // FIFO fills, third offer waits for a pop.
        set_in(1, 5'd3, 32'h33, 1, 5'd10, 32'hA, 0);
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd11, 32'hB, 0);
        #1 chk("t3_ready_b", 32'(llu_ready), 32'd1);
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd12, 32'hC, 0);
        #1 chk("t3_full_ready", 32'(llu_ready), 32'd0);
        tick;
        set_in(0, 0, 0, 1, 5'd12, 32'hC, 0);
        #1;
        chk("t3_pop_ready", 32'(llu_ready), 32'd0);
        chk("t3_pop_wsel", 32'(rf_wsel), 32'd10);
        tick;
        #1;
        chk("t3_accept_ready", 32'(llu_ready), 32'd1);
        chk("t3_second_wsel", 32'(rf_wsel), 32'd11);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t3_third_wsel", 32'(rf_wsel), 32'd12);
        tick;
        tick;

        // Pipe write to r0 yields the port; LLU result to r0 is dropped.
        set_in(1, 5'd3, 32'h33, 1, 5'd9, 32'h99, 0);
        tick;
        set_in(1, 5'd0, 32'h1234, 0, 0, 0, 0);
        #1;
        chk("t4_r0_wen", 32'(rf_wen), 32'd1);
        chk("t4_r0_wsel", 32'(rf_wsel), 32'd9);
        tick;
        set_in(0, 0, 0, 1, 5'd0, 32'h5555, 0);
        #1 chk("t4_llu_r0_ready", 32'(llu_ready), 32'd1);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1 chk("t4_llu_r0_nowrite", 32'(rf_wen), 32'd0);
        tick;

        // Halt drains two pending results in order.
        set_in(1, 5'd3, 32'h33, 1, 5'd20, 32'h20, 0);
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd21, 32'h21, 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 1);
        #1 chk("t5_first_wsel", 32'(rf_wsel), 32'd20);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_second_wsel", 32'(rf_wsel), 32'd21);
        chk("t5_not_halted", 32'(halt), 32'd0);
        tick;
        #1;
        chk("t5_halt", 32'(halt), 32'd1);
        chk("t5_ready_low", 32'(llu_ready), 32'd0);
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0);
        #1;
        chk("t5_halted_wen", 32'(rf_wen), 32'd0);
        chk("t5_halted_ready", 32'(llu_ready), 32'd0);
        tick;
        tick;

        // Reset with two pending entries discards them.
        set_in(0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        tick;
        nRST = 1'b1;
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd30, 32'h30, 0);
        tick;
        set_in(1, 5'd3, 32'h33, 1, 5'd31, 32'h31, 0);
        tick;
        set_in(0, 0, 0, 0, 0, 0, 0);
        nRST = 1'b0;
        #1;
        chk("t6_rst_wen", 32'(rf_wen), 32'd0);
        chk("t6_rst_halt", 32'(halt), 32'd0);
        chk("t6_rst_ready", 32'(llu_ready), 32'd1);
        tick;
        tick;
        nRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t6_no_stale_write", 32'(rf_wen), 32'd0);
        end
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
